// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the RAM port arbiter.
// FSM state encodings, port ids and the fixed-priority helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  function automatic logic fixed_pick(
    input logic data_prio
  );
    return data_prio ? PORT_D : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational 2-way picker.
// Chooses fetch or data port from the live requests.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR        = 1'b0,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant
);

  logic both;
  logic only_d;
  logic only_if;

  assign both    = if_req & d_req;
  assign only_d  = d_req & ~if_req;
  assign only_if = if_req & ~d_req;

  // a lone request wins; a tie goes to rotation or fixed priority
  always_comb begin
    grant = PORT_IF;
    unique case (1'b1)
      both: begin
        if (RR)
          grant = ~last_grant;
        else
          grant = fixed_pick(DATA_PRIO);
      end
      only_d:  grant = PORT_D;
      only_if: grant = PORT_IF;
      default: grant = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered-read RAM port
// between instruction fetch and load/store, one op at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b1,
  parameter bit RR        = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta,
  output logic              busy
);

  arb_state_t state;
  arb_state_t nxt;

  logic              gnt;
  logic              any_req;
  logic              take;
  logic              last_grant;
  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  assign any_req = if_req | d_req;
  assign take    = (state == ST_IDLE) & any_req;

  mem_arb_pick #(
    .RR        (RR),
    .DATA_PRIO (DATA_PRIO)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (gnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  // next state: writes skip the read wait cycle
  always_comb begin
    nxt = ST_IDLE;
    unique case (state)
      ST_IDLE:   nxt = any_req ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: nxt = lat_we ? ST_ACK : ST_WAIT;
      ST_WAIT:   nxt = ST_ACK;
      ST_ACK:    nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // latch the winner's request; held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id     <= PORT_IF;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      last_grant <= PORT_IF;
    end else if (take) begin
      lat_id     <= gnt;
      last_grant <= gnt;
      if (gnt == PORT_D) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
      end else begin
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
      end
    end
  end

  // capture read data into the winner's register only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == ST_WAIT) begin
      if (lat_id == PORT_D)
        d_rdata  <= ram_douta;
      else
        if_rdata <= ram_douta;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign ram_wea   = (state == ST_ACCESS) & lat_we;
  assign ram_addra = lat_addr;
  assign ram_dina  = lat_wdata;
  assign if_ack    = (state == ST_ACK) & (lat_id == PORT_IF);
  assign d_ack     = (state == ST_ACK) & (lat_id == PORT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for the RAM port arbiter.
// Fixed-priority and round-robin instances, each with a RAM model.
module tb_mem_port_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_wea;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_mem = 1'b1;

  logic        if_req0 = 0, d_req0 = 0, d_we0 = 0;
  logic [11:0] if_addr0 = 0, d_addr0 = 0, addra0;
  logic [31:0] d_wdata0 = 0, if_rdata0, d_rdata0;
  logic [31:0] dina0, douta0;
  logic        if_ack0, d_ack0, wea0, busy0;

  logic        if_req1 = 0, d_req1 = 0, d_we1 = 0;
  logic [11:0] if_addr1 = 0, d_addr1 = 0, addra1;
  logic [31:0] d_wdata1 = 0, if_rdata1, d_rdata1;
  logic [31:0] dina1, douta1;
  logic        if_ack1, d_ack1, wea1, busy1;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];

  int n_chk = 0;
  int n_fail = 0;

  vec_t vecs [8];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .DATA_PRIO(1'b1), .RR(1'b0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req0), .if_addr(if_addr0),
    .if_rdata(if_rdata0), .if_ack(if_ack0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0),
    .d_wdata(d_wdata0), .d_rdata(d_rdata0), .d_ack(d_ack0),
    .ram_wea(wea0), .ram_addra(addra0), .ram_dina(dina0),
    .ram_douta(douta0), .busy(busy0)
  );

  mem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .DATA_PRIO(1'b1), .RR(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1),
    .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1),
    .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ack(d_ack1),
    .ram_wea(wea1), .ram_addra(addra1), .ram_dina(dina1),
    .ram_douta(douta1), .busy(busy1)
  );

  // registered-read, read-first RAM models
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 32'hA5A5_0000 | 32'(i);
        mem1[i] <= 32'hA5A5_0000 | 32'(i);
      end
      mem0[12'h010] <= 32'h2008_0005;
    end else begin
      if (wea0) mem0[addra0] <= dina0;
      if (wea1) mem1[addra1] <= dina1;
    end
    douta0 <= mem0[addra0];
    douta1 <= mem1[addra1];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn0(input vec_t v);
    int lat, wcnt, bcnt;
    logic got;
    lat = 0; wcnt = 0; bcnt = 0; got = 1'b0;
    @(negedge clk);
    if (v.port) begin
      d_req0 = 1; d_we0 = v.we;
      d_addr0 = v.addr; d_wdata0 = v.wdata;
    end else begin
      if_req0 = 1; if_addr0 = v.addr;
    end
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wea0) wcnt++;
      if (busy0) bcnt++;
      if (v.port ? d_ack0 : if_ack0) begin
        got = 1'b1;
        lat = c;
      end
    end
    if_req0 = 0; d_req0 = 0; d_we0 = 0;
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("wea_pulses", 32'(wcnt), 32'(v.exp_wea));
    chk("busy_cycles", 32'(bcnt), 32'(v.exp_lat));
    if (!v.we)
      chk("rdata", v.port ? d_rdata0 : if_rdata0, v.exp_rd);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (!v.we)
      chk("rdata_held", v.port ? d_rdata0 : if_rdata0, v.exp_rd);
    chk("idle_after", 32'({d_ack0, if_ack0, busy0}), 32'd0);
  endtask

  task automatic mon0(input int is, input int ds,
                      input logic [11:0] ia, input logic [11:0] da,
                      input logic dwe, input logic [31:0] dwd,
                      output int ic, output int dc,
                      output logic [15:0] bm);
    ic = 0; dc = 0; bm = '0;
    @(negedge clk);
    if_addr0 = ia; d_addr0 = da; d_we0 = dwe; d_wdata0 = dwd;
    if (is == 0) if_req0 = 1;
    if (ds == 0) d_req0 = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      bm[c] = busy0;
      if (if_ack0 && ic == 0) begin
        ic = c; if_req0 = 0;
      end
      if (d_ack0 && dc == 0) begin
        dc = c; d_req0 = 0; d_we0 = 0;
      end
      if (is == c) if_req0 = 1;
      if (ds == c) d_req0 = 1;
    end
    if_req0 = 0; d_req0 = 0; d_we0 = 0;
  endtask

  initial begin
    int ic, dc, n, acks;
    logic [15:0] bm;
    logic ri, rd;
    int order [4];
    int exp_ord [4];
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 12'h010, 32'h0, 32'h2008_0005, 3, 0};
    vecs[1] = '{1'b1, 1'b1, 12'h100, 32'hDEAD_BEEF, 32'h0, 2, 1};
    vecs[2] = '{1'b1, 1'b0, 12'h100, 32'h0, 32'hDEAD_BEEF, 3, 0};
    vecs[3] = '{1'b1, 1'b0, 12'h010, 32'h0, 32'h2008_0005, 3, 0};
    vecs[4] = '{1'b1, 1'b1, 12'hFFF, 32'h1234_5678, 32'h0, 2, 1};
    vecs[5] = '{1'b0, 1'b0, 12'hFFF, 32'h0, 32'h1234_5678, 3, 0};
    vecs[6] = '{1'b0, 1'b0, 12'h000, 32'h0, 32'hA5A5_0000, 3, 0};
    vecs[7] = '{1'b1, 1'b0, 12'h001, 32'h0, 32'hA5A5_0001, 3, 0};

    // reset state
    #12;
    chk("rst_ctrl", 32'({wea0, if_ack0, d_ack0, busy0}), 32'd0);
    chk("rst_addra", 32'(addra0), 32'd0);
    chk("rst_dina", dina0, 32'd0);
    chk("rst_if_rdata", if_rdata0, 32'd0);
    chk("rst_d_rdata", d_rdata0, 32'd0);
    @(negedge clk);
    load_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'({busy0, busy1}), 32'd0);

    for (int i = 0; i < 8; i++)
      txn0(vecs[i]);

    // simultaneous loads: data first, fetch after
    mon0(0, 0, 12'h010, 12'h100, 1'b0, 32'h0, ic, dc, bm);
    chk("cont_d_ack", 32'(dc), 32'd3);
    chk("cont_if_ack", 32'(ic), 32'd7);
    chk("cont_busy", 32'(bm), 32'h0000_00EE);
    chk("cont_if_rdata", if_rdata0, 32'h2008_0005);
    chk("cont_d_rdata", d_rdata0, 32'hDEAD_BEEF);

    // simultaneous store and fetch
    mon0(0, 0, 12'h050, 12'h200, 1'b1, 32'h0BAD_F00D, ic, dc, bm);
    chk("cont_w_d_ack", 32'(dc), 32'd2);
    chk("cont_w_if_ack", 32'(ic), 32'd6);
    chk("cont_w_busy", 32'(bm), 32'h0000_0076);
    chk("cont_w_if_rdata", if_rdata0, 32'hA5A5_0050);
    chk("cont_w_d_rdata", d_rdata0, 32'hDEAD_BEEF);
    v = '{1'b1, 1'b0, 12'h200, 32'h0, 32'h0BAD_F00D, 3, 0};
    txn0(v);

    // fetch raised during a data WAIT waits for IDLE
    mon0(2, 0, 12'h040, 12'h100, 1'b0, 32'h0, ic, dc, bm);
    chk("busy_d_ack", 32'(dc), 32'd3);
    chk("busy_if_ack", 32'(ic), 32'd7);
    chk("busy_map", 32'(bm), 32'h0000_00EE);
    chk("busy_if_rdata", if_rdata0, 32'hA5A5_0040);

    // round robin with both requests kept asserted
    exp_ord[0] = 1; exp_ord[1] = 0;
    exp_ord[2] = 1; exp_ord[3] = 0;
    for (int i = 0; i < 4; i++) order[i] = 2;
    n = 0; ri = 0; rd = 0;
    @(negedge clk);
    if_addr1 = 12'h030; d_addr1 = 12'h020; d_we1 = 0;
    if_req1 = 1; d_req1 = 1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ri) begin if_req1 = 1; ri = 0; end
      if (rd) begin d_req1 = 1; rd = 0; end
      if (if_ack1 && n < 4) begin
        order[n] = 0; n++; if_req1 = 0; ri = 1;
      end
      if (d_ack1 && n < 4) begin
        order[n] = 1; n++; d_req1 = 0; rd = 1;
      end
    end
    if_req1 = 0; d_req1 = 0;
    chk("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(exp_ord[i]));
    chk("rr_if_rdata", if_rdata1, 32'hA5A5_0030);
    chk("rr_d_rdata", d_rdata1, 32'hA5A5_0020);

    // reset in the middle of a store
    repeat (3) @(negedge clk);
    d_req0 = 1; d_we0 = 1;
    d_addr0 = 12'h300; d_wdata0 = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wea_pre", 32'(wea0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wea_cut", 32'(wea0), 32'd0);
    chk("mid_ctrl", 32'({busy0, if_ack0, d_ack0}), 32'd0);
    chk("mid_addra", 32'(addra0), 32'd0);
    chk("mid_dina", dina0, 32'd0);
    chk("mid_rdata", if_rdata0 | d_rdata0, 32'd0);
    d_req0 = 0; d_we0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (d_ack0 || if_ack0 || busy0) acks++;
    end
    chk("mid_no_ack", 32'(acks), 32'd0);
    v = '{1'b1, 1'b0, 12'h300, 32'h0, 32'hA5A5_0300, 3, 0};
    txn0(v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
